// File: rtl/mux16_scan_serializer_if.sv
// Handshake and mux-side bundle between the 16:1 mux scan serializer and its environment.
// slave is the serializer's view; master is the view of the upstream/mux/downstream side.
interface mux16_scan_serializer_if;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned SEL_W  = 4;
   localparam int unsigned CNT_W  = 5;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [SEL_W-1:0]  mux_s;
   logic [DATA_W-1:0] mux_d;
   logic              mux_y;
   logic              ser_valid;
   logic              ser_ready;
   logic              ser_bit;
   logic              ser_last;
   logic              done;
   logic [CNT_W-1:0]  ones_cnt;
   logic              err;

   modport master (
      output in_valid, in_data, mux_y, ser_ready,
      input  in_ready, mux_s, mux_d, ser_valid, ser_bit, ser_last, done, ones_cnt, err
   );

   modport slave (
      input  in_valid, in_data, mux_y, ser_ready,
      output in_ready, mux_s, mux_d, ser_valid, ser_bit, ser_last, done, ones_cnt, err
   );
endinterface

// File: rtl/mux16_scan_serializer.sv
// Drives a 16:1 bit mux with an accepted word, scans all channels as a backpressured serial
// stream, and counts ones / flags any mux output bit that disagrees with the registered word.
module mux16_scan_serializer #(
   parameter bit MSB_FIRST = 1'b0
) (
   input logic                    clk,
   input logic                    rst,
   mux16_scan_serializer_if.slave bus
);
   localparam int unsigned DATA_W = 16;
   localparam int unsigned SEL_W  = 4;
   localparam int unsigned CNT_W  = 5;
   localparam int unsigned BEAT_W = 4;

   localparam logic [SEL_W-1:0]  SEL_START     = MSB_FIRST ? SEL_W'(DATA_W - 1) : SEL_W'(0);
   localparam logic [BEAT_W-1:0] BEAT_PRE_LAST = BEAT_W'(DATA_W - 2);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t state_q, state_n;

   logic              in_ready_q,  in_ready_n;
   logic              ser_valid_q, ser_valid_n;
   logic              ser_last_q,  ser_last_n;
   logic              done_q,      done_n;
   logic              err_q,       err_n;
   logic [SEL_W-1:0]  mux_s_q,     mux_s_n;
   logic [DATA_W-1:0] mux_d_q,     mux_d_n;
   logic [CNT_W-1:0]  ones_q,      ones_n;
   logic [BEAT_W-1:0] beat_q,      beat_n;

   logic beat_acc_c;
   logic bit_mismatch_c;

   assign beat_acc_c     = ser_valid_q && bus.ser_ready;
   assign bit_mismatch_c = (bus.mux_y != mux_d_q[mux_s_q]);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_n;
      end
   end

   // Registered outputs and datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_ready_q  <= 1'b1;
         ser_valid_q <= 1'b0;
         ser_last_q  <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         mux_s_q     <= '0;
         mux_d_q     <= '0;
         ones_q      <= '0;
         beat_q      <= '0;
      end else begin
         in_ready_q  <= in_ready_n;
         ser_valid_q <= ser_valid_n;
         ser_last_q  <= ser_last_n;
         done_q      <= done_n;
         err_q       <= err_n;
         mux_s_q     <= mux_s_n;
         mux_d_q     <= mux_d_n;
         ones_q      <= ones_n;
         beat_q      <= beat_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n     = state_q;
      in_ready_n  = in_ready_q;
      ser_valid_n = ser_valid_q;
      ser_last_n  = ser_last_q;
      done_n      = 1'b0;
      err_n       = err_q;
      mux_s_n     = mux_s_q;
      mux_d_n     = mux_d_q;
      ones_n      = ones_q;
      beat_n      = beat_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               state_n     = SCAN;
               in_ready_n  = 1'b0;
               ser_valid_n = 1'b1;
               ser_last_n  = 1'b0;
               mux_d_n     = bus.in_data;
               mux_s_n     = SEL_START;
               beat_n      = '0;
               ones_n      = '0;
            end
         end

         SCAN: begin
            if (beat_acc_c) begin
               ones_n = ones_q + CNT_W'(bus.mux_y);
               if (bit_mismatch_c) begin
                  err_n = 1'b1;
               end
               beat_n     = beat_q + BEAT_W'(1);
               mux_s_n    = MSB_FIRST ? (mux_s_q - SEL_W'(1)) : (mux_s_q + SEL_W'(1));
               ser_last_n = (beat_q == BEAT_PRE_LAST);
               // Final beat: back to IDLE with a one-cycle done pulse
               if (ser_last_q) begin
                  state_n     = IDLE;
                  in_ready_n  = 1'b1;
                  ser_valid_n = 1'b0;
                  ser_last_n  = 1'b0;
                  done_n      = 1'b1;
                  mux_s_n     = SEL_START;
               end
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.ser_valid = ser_valid_q;
   assign bus.ser_last  = ser_last_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.mux_s     = mux_s_q;
   assign bus.mux_d     = mux_d_q;
   assign bus.ones_cnt  = ones_q;
   // Serial bit comes straight through the external mux, one mux delay after mux_s_q
   assign bus.ser_bit   = bus.mux_y;

endmodule

// File: tb/tb_mux16_scan_serializer.sv
// Directed bench for mux16_scan_serializer: LSB-first and MSB-first instances share clk/rst,
// a behavioral 16:1 mux closes the loop, and sel chooses which instance is stimulated/observed.
module tb_mux16_scan_serializer;
   logic clk;
   logic rst;

   logic        sel;
   logic        in_valid_t;
   logic [15:0] in_data_t;
   logic        ser_ready_t;
   logic        fault_t;
   logic        err_exp;

   int n_chk;
   int n_err;

   mux16_scan_serializer_if if0 ();
   mux16_scan_serializer_if if1 ();

   mux16_scan_serializer #(.MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(if0.slave));
   mux16_scan_serializer #(.MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(if1.slave));

   // Behavioral 16:1 mux with an injectable bit inversion on the LSB-first instance
   assign if0.mux_y     = if0.mux_d[if0.mux_s] ^ (fault_t & ~sel);
   assign if1.mux_y     = if1.mux_d[if1.mux_s];
   assign if0.in_valid  = in_valid_t & ~sel;
   assign if1.in_valid  = in_valid_t & sel;
   assign if0.in_data   = in_data_t;
   assign if1.in_data   = in_data_t;
   assign if0.ser_ready = sel ? 1'b1 : ser_ready_t;
   assign if1.ser_ready = sel ? ser_ready_t : 1'b1;

   wire        obs_in_ready  = sel ? if1.in_ready  : if0.in_ready;
   wire [3:0]  obs_mux_s     = sel ? if1.mux_s     : if0.mux_s;
   wire [15:0] obs_mux_d     = sel ? if1.mux_d     : if0.mux_d;
   wire        obs_ser_valid = sel ? if1.ser_valid : if0.ser_valid;
   wire        obs_ser_bit   = sel ? if1.ser_bit   : if0.ser_bit;
   wire        obs_ser_last  = sel ? if1.ser_last  : if0.ser_last;
   wire        obs_done      = sel ? if1.done      : if0.done;
   wire [4:0]  obs_ones_cnt  = sel ? if1.ones_cnt  : if0.ones_cnt;
   wire        obs_err       = sel ? if1.err       : if0.err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_values();
      check("rst_in_ready",  obs_in_ready,  1);
      check("rst_mux_s",     obs_mux_s,     0);
      check("rst_mux_d",     obs_mux_d,     0);
      check("rst_ser_valid", obs_ser_valid, 0);
      check("rst_ser_last",  obs_ser_last,  0);
      check("rst_done",      obs_done,      0);
      check("rst_ones_cnt",  obs_ones_cnt,  0);
      check("rst_err",       obs_err,       0);
   endtask

   // Offer one word at a negedge; returns at the negedge of the first beat cycle
   task automatic accept(input logic [15:0] data);
      in_valid_t = 1'b1;
      in_data_t  = data;
      @(posedge clk);
      @(negedge clk);
      in_valid_t = 1'b0;
   endtask

   // Walks a word beat by beat from the first beat cycle; returns at the negedge of the done cycle
   task automatic scan(input logic [15:0] data, input bit msb, input bit stall,
                       input int fault_beat, input logic [4:0] exp_ones);
      int beat;
      int cyc;
      int ch;
      beat = 0;
      cyc  = 0;
      while (beat < 16 && cyc < 200) begin
         ch = msb ? (15 - beat) : beat;
         fault_t = (beat == fault_beat);
         #1;
         check("scan_in_ready", obs_in_ready, 0);
         check("ser_valid",     obs_ser_valid, 1);
         check("mux_d",         obs_mux_d, data);
         check("mux_s",         obs_mux_s, ch);
         check("ser_last",      obs_ser_last, (beat == 15));
         check("scan_done",     obs_done, 0);
         check("err",           obs_err, err_exp);
         check("ser_bit",       obs_ser_bit, data[ch] ^ fault_t);
         ser_ready_t = stall ? (cyc % 3 == 0) : 1'b1;
         @(posedge clk);
         if (ser_ready_t) begin
            if (beat == fault_beat) err_exp = 1'b1;
            beat++;
         end
         @(negedge clk);
         cyc++;
      end
      fault_t = 1'b0;
      check("beat_count",     beat, 16);
      check("done",           obs_done, 1);
      check("ones_cnt",       obs_ones_cnt, exp_ones);
      check("done_in_ready",  obs_in_ready, 1);
      check("done_ser_valid", obs_ser_valid, 0);
      check("done_err",       obs_err, err_exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      n_chk       = 0;
      n_err       = 0;
      sel         = 1'b0;
      rst         = 1'b1;
      in_valid_t  = 1'b0;
      in_data_t   = '0;
      ser_ready_t = 1'b1;
      fault_t     = 1'b0;
      err_exp     = 1'b0;

      repeat (2) @(negedge clk);
      check_reset_values();
      check("rst_msb_mux_s", if1.mux_s, 0);
      rst = 1'b0;
      @(negedge clk);

      // LSB-first A5C3: bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, eight ones
      accept(16'hA5C3);
      scan(16'hA5C3, 1'b0, 1'b0, -1, 5'd8);
      @(negedge clk);
      check("done_pulse_width", obs_done, 0);
      check("ones_cnt_held",    obs_ones_cnt, 8);

      // MSB-first 8001: select walks 15..0, first and last bits set
      sel = 1'b1;
      @(negedge clk);
      accept(16'h8001);
      scan(16'h8001, 1'b1, 1'b0, -1, 5'd2);
      @(negedge clk);
      sel = 1'b0;
      @(negedge clk);

      // All ones with ready pattern 1,0,0 repeating: sixteen ones without overflow
      accept(16'hFFFF);
      scan(16'hFFFF, 1'b0, 1'b1, -1, 5'd16);
      @(negedge clk);

      // Back-to-back with in_valid held high; second accept lands in the done cycle
      in_valid_t = 1'b1;
      in_data_t  = 16'h0001;
      @(posedge clk);
      @(negedge clk);
      in_data_t = 16'h8000;
      scan(16'h0001, 1'b0, 1'b0, -1, 5'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid_t = 1'b0;
      scan(16'h8000, 1'b0, 1'b0, -1, 5'd1);
      @(negedge clk);
      check("b2b_idle_ready", obs_in_ready, 1);

      // Inverted mux output on beat 5 (a 0 bit read as 1): err sticks, nine ones counted
      accept(16'hA5C3);
      scan(16'hA5C3, 1'b0, 1'b0, 5, 5'd9);
      @(negedge clk);
      accept(16'h0F0F);
      scan(16'h0F0F, 1'b0, 1'b0, -1, 5'd8);
      @(negedge clk);
      check("err_sticky_idle", obs_err, 1);

      // Reset while beat 7 is presented
      accept(16'h1234);
      repeat (7) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("pre_rst_mux_s", obs_mux_s, 7);
      rst = 1'b1;
      #1;
      check_reset_values();
      err_exp = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("rst_no_done", obs_done, 0);
      end
      rst = 1'b0;
      @(negedge clk);
      accept(16'h1234);
      scan(16'h1234, 1'b0, 1'b0, -1, 5'd5);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
